mdu_ctrl: RTL

- Multiply/divide unit with controller for the pipelined MIPS datapath; sits in the E stage beside the ALU.
- Sequences multi-cycle mult/multu/div/divu, owns the HI/LO registers, and serves mfhi/mflo/mthi/mtlo.
- Exposes Start/Busy so the hazard unit can stall dependent MDU instructions.

---
 rtl/mdu_ctrl_pkg.sv | 26 ++
 rtl/mdu_arith.sv | 50 +++++
 rtl/mdu_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/mdu_ctrl_pkg.sv
// Shared encodings for the E-stage multiply/divide unit: MDUop codes, FSM states,
// operation classes and default latencies.
package mdu_ctrl_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MFHI  = 4'd5;
  localparam logic [3:0] MDU_MFLO  = 4'd6;
  localparam logic [3:0] MDU_MTHI  = 4'd7;
  localparam logic [3:0] MDU_MTLO  = 4'd8;

  localparam int DEFAULT_MULT_CYCLES = 5;
  localparam int DEFAULT_DIV_CYCLES  = 10;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  typedef enum logic [1:0] {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU} op_class_t;

  function automatic logic is_start_op(input logic [3:0] op);
    return (op >= MDU_MULT) && (op <= MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath for the MDU: 32x32 multiply and divide, signed or unsigned,
// producing {hi,lo} and a divide-by-zero flag.
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  op_class_t   i_class,
  output logic [63:0] o_result,
  output logic        o_div_zero
);

  logic        w_signed;
  logic        w_is_div;
  logic [63:0] w_a_ext;
  logic [63:0] w_b_ext;
  logic [63:0] w_prod;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_divisor;
  logic [31:0] w_quo_mag;
  logic [31:0] w_rem_mag;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  assign w_signed = (i_class == OP_MULT) || (i_class == OP_DIV);
  assign w_is_div = (i_class == OP_DIV) || (i_class == OP_DIVU);

  // A 64-bit product of sign-extended operands, truncated, is the exact signed product.
  assign w_a_ext = {{32{w_signed & i_a[31]}}, i_a};
  assign w_b_ext = {{32{w_signed & i_b[31]}}, i_b};
  assign w_prod  = w_a_ext * w_b_ext;

  // Divide on magnitudes so truncation toward zero and remainder sign are explicit.
  assign w_a_neg   = w_signed & i_a[31];
  assign w_b_neg   = w_signed & i_b[31];
  assign w_a_mag   = w_a_neg ? -i_a : i_a;
  assign w_b_mag   = w_b_neg ? -i_b : i_b;
  assign w_divisor = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
  assign w_quo_mag = w_a_mag / w_divisor;
  assign w_rem_mag = w_a_mag % w_divisor;
  assign w_quo     = (w_a_neg ^ w_b_neg) ? -w_quo_mag : w_quo_mag;
  assign w_rem     = w_a_neg ? -w_rem_mag : w_rem_mag;

  assign o_div_zero = w_is_div && (i_b == 32'd0);
  assign o_result   = w_is_div ? {w_rem, w_quo} : w_prod;

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: IDLE/BUSY sequencing of mult/div, HI/LO ownership, mfhi/mflo/mthi/mtlo.
// Define MDU_CANCEL_EN to add the Req port that suppresses Start and mthi/mtlo.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUop,
  input  logic [31:0] A,
  input  logic [31:0] B,
`ifdef MDU_CANCEL_EN
  input  logic        Req,
`endif
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUout
);

  state_t      r_state;
  logic [3:0]  r_count;
  logic [31:0] r_a;
  logic [31:0] r_b;
  op_class_t   r_class;
  logic        r_busy;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_cancel;
  logic        w_start;
  op_class_t   w_class;
  logic [3:0]  w_latency;
  logic [63:0] w_result;
  logic        w_div_zero;

`ifdef MDU_CANCEL_EN
  assign w_cancel = Req;
`else
  assign w_cancel = 1'b0;
`endif

  assign w_start = (r_state == S_IDLE) && is_start_op(MDUop) && !w_cancel;

  always_comb begin
    w_class = OP_MULT;
    case (MDUop)
      MDU_MULTU: w_class = OP_MULTU;
      MDU_DIV:   w_class = OP_DIV;
      MDU_DIVU:  w_class = OP_DIVU;
      default:   w_class = OP_MULT;
    endcase
  end

  assign w_latency = ((MDUop == MDU_MULT) || (MDUop == MDU_MULTU)) ?
                     4'(MULT_CYCLES) : 4'(DIV_CYCLES);

  mdu_arith u_arith (
    .i_a        (r_a),
    .i_b        (r_b),
    .i_class    (r_class),
    .o_result   (w_result),
    .o_div_zero (w_div_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_count <= 4'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_class <= OP_MULT;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_a     <= A;
            r_b     <= B;
            r_class <= w_class;
            r_count <= w_latency;
            r_state <= S_BUSY;
            r_busy  <= 1'b1;
          end else if (!w_cancel) begin
            if (MDUop == MDU_MTHI) r_hi <= A;
            if (MDUop == MDU_MTLO) r_lo <= A;
          end
        end
        S_BUSY: begin
          r_count <= r_count - 4'd1;
          // Write-back happens on the edge where the counter reaches zero.
          if (r_count == 4'd1) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            if (!w_div_zero) begin
              r_hi <= w_result[63:32];
              r_lo <= w_result[31:0];
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Start  = w_start;
  assign Busy   = r_busy;
  assign HI     = r_hi;
  assign LO     = r_lo;
  assign MDUout = (MDUop == MDU_MFHI) ? r_hi :
                  (MDUop == MDU_MFLO) ? r_lo : 32'd0;

endmodule
